// File: rtl/axis_gray_pkg.sv
// Shared definitions for the RGB-to-luma AXI-Stream converter.
// Optional build macro: AXIS_GRAY_ROUND_EN (round-to-nearest luma).
package axis_gray_pkg;

    // Which colour sample the next accepted input beat carries.
    typedef enum logic [1:0] {
        S_R = 2'd0,
        S_G = 2'd1,
        S_B = 2'd2
    } state_t;

    // Default BT.601-style weights in Q0.8; they sum to 256.
    localparam int DEF_COEF_R = 77;
    localparam int DEF_COEF_G = 150;
    localparam int DEF_COEF_B = 29;

    // Width of the weighted-sum accumulator.
    localparam int ACC_WIDTH = 18;

endpackage

// File: rtl/gray_mac.sv
// Combinational weighted sum of one RGB pixel, producing a luma sample.
// Build macro AXIS_GRAY_ROUND_EN: when defined, half an LSB (128) is added
// before the Q0.8 shift so the result rounds to nearest; otherwise it
// truncates. The maximum sum (65280, or 65408 with rounding) always fits
// in 16 bits, so no saturation is required.
module gray_mac
    import axis_gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_R     = DEF_COEF_R,
    parameter int COEF_G     = DEF_COEF_G,
    parameter int COEF_B     = DEF_COEF_B
) (
    input  logic [DATA_WIDTH-1:0] r,
    input  logic [DATA_WIDTH-1:0] g,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] luma
);

    localparam logic [ACC_WIDTH-1:0] CR = ACC_WIDTH'(COEF_R);
    localparam logic [ACC_WIDTH-1:0] CG = ACC_WIDTH'(COEF_G);
    localparam logic [ACC_WIDTH-1:0] CB = ACC_WIDTH'(COEF_B);

`ifdef AXIS_GRAY_ROUND_EN
    localparam logic [ACC_WIDTH-1:0] BIAS = ACC_WIDTH'(128);
`else
    localparam logic [ACC_WIDTH-1:0] BIAS = '0;
`endif

    logic [ACC_WIDTH-1:0] r_w;
    logic [ACC_WIDTH-1:0] g_w;
    logic [ACC_WIDTH-1:0] b_w;
    logic [ACC_WIDTH-1:0] sum;
    logic                 unused_bits;

    assign r_w = ACC_WIDTH'(r);
    assign g_w = ACC_WIDTH'(g);
    assign b_w = ACC_WIDTH'(b);

    // Weighted sum plus optional rounding bias, then drop the 8 fraction bits.
    always_comb begin
        sum  = CR * r_w + CG * g_w + CB * b_w + BIAS;
        luma = sum[DATA_WIDTH+7:8];
    end

    // Fraction and headroom bits are intentionally discarded.
    assign unused_bits = ^{sum[ACC_WIDTH-1:DATA_WIDTH+8], sum[7:0]};

endmodule

// File: rtl/axis_rgb2gray.sv
// AXI-Stream RGB-to-luma converter. Consumes interleaved R,G,B byte beats
// and emits one luma sample per pixel through a single-entry output
// register, counting transferred pixels.
// Build macro AXIS_GRAY_ROUND_EN selects round-to-nearest luma (see gray_mac).
module axis_rgb2gray
    import axis_gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_R     = DEF_COEF_R,
    parameter int COEF_G     = DEF_COEF_G,
    parameter int COEF_B     = DEF_COEF_B,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [CNT_WIDTH-1:0]  pix_cnt
);

    // Weights must describe a unity-gain Q0.8 filter.
    generate
        if (COEF_R + COEF_G + COEF_B != 256) begin : g_coef_check
            $error("axis_rgb2gray: COEF_R + COEF_G + COEF_B must equal 256");
        end
    endgenerate

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] r_reg;
    logic [DATA_WIDTH-1:0] g_reg;
    logic [DATA_WIDTH-1:0] luma;
    logic                  in_hs;
    logic                  out_hs;
    logic                  load;

    gray_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_R     (COEF_R),
        .COEF_G     (COEF_G),
        .COEF_B     (COEF_B)
    ) u_mac (
        .r    (r_reg),
        .g    (g_reg),
        .b    (s_tdata),
        .luma (luma)
    );

    // R and G are always accepted; B only when the output slot is free or draining.
    always_comb begin
        s_tready = (state_reg != S_B) || !m_tvalid || m_tready;
        in_hs    = s_tvalid && s_tready;
        out_hs   = m_tvalid && m_tready;
        load     = in_hs && (state_reg == S_B);
    end

    // Sample-sequencing FSM; advances and captures only on an input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_R;
            r_reg     <= '0;
            g_reg     <= '0;
        end else if (in_hs) begin
            case (state_reg)
                S_R: begin
                    r_reg     <= s_tdata;
                    state_reg <= S_G;
                end
                S_G: begin
                    g_reg     <= s_tdata;
                    state_reg <= S_B;
                end
                S_B:     state_reg <= S_R;
                default: state_reg <= S_R;
            endcase
        end
    end

    // Output register: a new pixel load wins over a simultaneous drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= luma;
        end else if (out_hs) begin
            m_tvalid <= 1'b0;
        end
    end

    // Count completed output transfers, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (out_hs) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_rgb2gray.sv
// Directed self-checking bench for axis_rgb2gray (4-bit pixel counter so
// that wrap-around is reachable quickly).
module tb_axis_rgb2gray;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] s_tdata = 8'd0;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic [7:0] m_tdata;
    logic [3:0] pix_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         rdy_rand = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    axis_rgb2gray #(
        .DATA_WIDTH (8),
        .COEF_R     (77),
        .COEF_G     (150),
        .COEF_B     (29),
        .CNT_WIDTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .pix_cnt  (pix_cnt)
    );

    always #5 clk = ~clk;

`ifdef AXIS_GRAY_ROUND_EN
    localparam int EXP_BLUE = 29;
    localparam int RND = 128;
`else
    localparam int EXP_BLUE = 28;
    localparam int RND = 0;
`endif

    // Independent luma reference.
    function automatic logic [7:0] luma_ref(input int r, input int g, input int b);
        int s;
        s = 77 * r + 150 * g + 29 * b + RND;
        return 8'(s / 256);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input beat, held until accepted (bounded).
    task automatic send_beat(input logic [7:0] d);
        bit done;
        done = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_tready) done = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
        if (!done) check_val("beat_timeout", 32'(s_tready), 32'd1);
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        send_beat(r);
        send_beat(g);
        send_beat(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_async_valid", 32'(m_tvalid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Output-handshake monitor, one line per transferred pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                $display("pixel out: luma=%0d pix_cnt_before=%0d", m_tdata, pix_cnt);
            end
        end
    end

    // Random downstream backpressure (ready 3 cycles in 4 on average).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int exp_cnt;
        int rr, gg, bb;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_val("reset_m_tvalid", 32'(m_tvalid), 32'd0);
        check_val("reset_m_tdata", 32'(m_tdata), 32'd0);
        check_val("reset_pix_cnt", 32'(pix_cnt), 32'd0);
        check_val("reset_s_tready", 32'(s_tready), 32'd1);

        // White pixel: one-cycle latency, single-cycle valid pulse
        m_tready = 1'b1;
        send_pixel(8'd255, 8'd255, 8'd255);
        check_val("white_valid", 32'(m_tvalid), 32'd1);
        check_val("white_data", 32'(m_tdata), 32'd255);
        tick();
        check_val("white_valid_pulse", 32'(m_tvalid), 32'd0);
        check_val("white_cnt", 32'(pix_cnt), 32'd1);

        // Pure blue (rounding-dependent) and pure red
        send_pixel(8'd0, 8'd0, 8'd255);
        check_val("blue_data", 32'(m_tdata), 32'(EXP_BLUE));
        send_pixel(8'd100, 8'd0, 8'd0);
        check_val("red_data", 32'(m_tdata), 32'd30);
        tick();
        check_val("red_cnt", 32'(pix_cnt), 32'd3);

        // Backpressure: one buffered pixel, R/G of next still accepted, stall in S_B
        got.delete();
        m_tready = 1'b0;
        send_pixel(8'd0, 8'd200, 8'd0);
        check_val("bp_first_valid", 32'(m_tvalid), 32'd1);
        check_val("bp_first_data", 32'(m_tdata), 32'd117);
        send_beat(8'd255);
        send_beat(8'd255);
        s_tvalid = 1'b1;
        s_tdata  = 8'd255;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_stall_ready", 32'(s_tready), 32'd0);
            check_val("bp_hold_data", 32'(m_tdata), 32'd117);
            tick();
        end
        m_tready = 1'b1;
        @(negedge clk);
        check_val("bp_release_ready", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 1'b0;
        check_val("bp_second_valid", 32'(m_tvalid), 32'd1);
        check_val("bp_second_data", 32'(m_tdata), 32'd255);
        tick();
        check_val("bp_drained", 32'(m_tvalid), 32'd0);
        check_val("bp_order_n", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check_val("bp_order_0", 32'(got[0]), 32'd117);
            check_val("bp_order_1", 32'(got[1]), 32'd255);
        end
        check_val("bp_cnt", 32'(pix_cnt), 32'd5);

        // Random gaps with random backpressure
        got.delete();
        exp_q.delete();
        rdy_rand = 1'b1;
        for (int p = 0; p < 20; p++) begin
            rr = $urandom_range(0, 255);
            gg = $urandom_range(0, 255);
            bb = $urandom_range(0, 255);
            exp_q.push_back(luma_ref(rr, gg, bb));
            repeat ($urandom_range(0, 2)) tick();
            send_beat(8'(rr));
            repeat ($urandom_range(0, 1)) tick();
            send_beat(8'(gg));
            send_beat(8'(bb));
        end
        rdy_rand = 1'b0;
        m_tready = 1'b1;
        repeat (4) tick();
        check_val("rand_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            check_val($sformatf("rand_pix%0d", i), 32'(got[i]), 32'(exp_q[i]));
        check_val("rand_cnt", 32'(pix_cnt), 32'((5 + 20) % 16));

        // Reset mid-pixel with a pending output: both are discarded
        got.delete();
        m_tready = 1'b0;
        send_pixel(8'd100, 8'd0, 8'd0);
        send_beat(8'd10);
        send_beat(8'd20);
        do_reset();
        check_val("rst_mid_cnt", 32'(pix_cnt), 32'd0);
        check_val("rst_mid_data", 32'(m_tdata), 32'd0);
        m_tready = 1'b1;
        send_pixel(8'd0, 8'd0, 8'd255);
        repeat (3) tick();
        check_val("rst_mid_n", 32'(got.size()), 32'd1);
        if (got.size() == 1) check_val("rst_mid_pix", 32'(got[0]), 32'(EXP_BLUE));
        check_val("rst_mid_cnt1", 32'(pix_cnt), 32'd1);

        // Counter wrap: 17 pixels into a 4-bit counter
        do_reset();
        exp_cnt = 0;
        for (int p = 0; p < 17; p++) begin
            send_pixel(8'(p), 8'(p * 3), 8'(p * 7));
            exp_cnt = (exp_cnt + 1) % 16;
        end
        tick();
        check_val("wrap_cnt", 32'(pix_cnt), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
